// File: rtl/pbit_sweep_scheduler.sv
// pbit_sweep_scheduler: round-robin Gibbs update sequencer with burn-in and per-sweep sample strobes.
// Outputs are registered one cycle behind the internal phase/select counters.
module pbit_sweep_scheduler #(
    parameter int N_PBITS        = 5,
    parameter int CYC_PER_UPDATE = 3,
    parameter int SAMP_W         = 16,
    parameter int BURN_W         = 8,
    localparam int SW = N_PBITS > 1 ? $clog2(N_PBITS) : 1,
    localparam int PW = CYC_PER_UPDATE > 1 ? $clog2(CYC_PER_UPDATE) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              stop,
    input  logic [SAMP_W-1:0] n_samples,
    input  logic [BURN_W-1:0] burnin,
    output logic [SW-1:0]     sel,
    output logic [PW-1:0]     phase,
    output logic [N_PBITS-1:0] upd_en,
    output logic              sweep_done,
    output logic              sample_valid,
    output logic [SAMP_W-1:0] sweep_count,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, BURN, SAMPLE, FINISH} state_t;
    localparam logic [PW-1:0] PMAX = PW'(CYC_PER_UPDATE - 1);
    localparam logic [SW-1:0] SMAX = SW'(N_PBITS - 1);

    state_t st, nxt;
    logic [PW-1:0] ph;
    logic [SW-1:0] sl;
    logic [SAMP_W-1:0] n_l, samp;
    logic [SAMP_W:0] samp_inc;
    logic [BURN_W-1:0] burn_l;
    logic stop_f, accept, halt, run, run_n, go, commit, eos;

    always_ff @(posedge CLK) begin
        if (RST) st <= IDLE;
        else     st <= nxt;
    end

    // State decisions are taken in the cycle sweep_done is visible, so they line up with the registered outputs.
    always_comb begin
        accept   = st == IDLE && start && !stop;
        halt     = stop_f || stop;
        samp_inc = {1'b0, samp} + {{SAMP_W{1'b0}}, 1'b1};
        nxt      = st;
        case (st)
            IDLE:    nxt = accept ? (burnin != '0 ? BURN : SAMPLE) : IDLE;
            BURN:    nxt = !sweep_done ? BURN : halt ? FINISH :
                           sweep_count == SAMP_W'(burn_l) ? SAMPLE : BURN;
            SAMPLE:  nxt = sweep_done && (halt || (n_l != '0 && samp_inc == {1'b0, n_l})) ? FINISH : SAMPLE;
            default: nxt = IDLE;
        endcase
        run    = st == BURN || st == SAMPLE;
        run_n  = nxt == BURN || nxt == SAMPLE;
        go     = run && run_n;
        commit = go && ph == PMAX;
        eos    = commit && sl == SMAX;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ph           <= '0;
            sl           <= '0;
            phase        <= '0;
            sel          <= '0;
            upd_en       <= '0;
            sweep_done   <= 1'b0;
            sweep_count  <= '0;
            sample_valid <= 1'b0;
            samp         <= '0;
            stop_f       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            n_l          <= '0;
            burn_l       <= '0;
        end else begin
            ph           <= go ? (ph == PMAX ? '0 : ph + PW'(1)) : '0;
            sl           <= !go ? '0 : ph != PMAX ? sl : sl == SMAX ? '0 : sl + SW'(1);
            phase        <= go ? ph : '0;
            sel          <= go ? sl : '0;
            upd_en       <= commit ? N_PBITS'(1) << sl : '0;
            sweep_done   <= eos;
            sweep_count  <= accept ? '0 : eos && ~&sweep_count ? sweep_count + SAMP_W'(1) : sweep_count;
            sample_valid <= st == SAMPLE && sweep_done;
            samp         <= accept ? '0 : st == SAMPLE && sweep_done ? samp_inc[SAMP_W-1:0] : samp;
            stop_f       <= run && halt;
            busy         <= run_n;
            done         <= st == FINISH;
            n_l          <= accept ? n_samples : n_l;
            burn_l       <= accept ? burnin : burn_l;
        end
    end
endmodule

// File: doc/pbit_sweep_scheduler.md
Name: pbit_sweep_scheduler

Overview:
- Sequences Gibbs updates of an N-p-bit network.
- Walks the p-bits in fixed round-robin order. Each p-bit gets CYC_PER_UPDATE cycles: field compute, compare, commit.
- Counts full sweeps, discards a programmable burn-in, and emits one sample strobe per post-burn-in sweep to the histogram/sampling logic.
- Sits between the run-control registers and the p-bit array; replaces free-running clock dividers for sweep-aligned sampling.

Parameters:
- N_PBITS, 5, number of p-bits sequenced.
- CYC_PER_UPDATE, 3, cycles allotted per p-bit update (>=1).
- SAMP_W, 16, width of sample target and sweep counter.
- BURN_W, 8, width of burn-in sweep count.

Ports:
- CLK  input  1  clock.
- RST  input  1  reset, synchronous, active-high.
- start  input  1  level; sampled only in IDLE.
- stop  input  1  level; requests graceful stop at end of current sweep.
- n_samples  input  SAMP_W  post-burn-in sweeps to sample; 0 = run until stop.
- burnin  input  BURN_W  sweeps discarded before sampling; latched at start.
- sel  output  clog2(N_PBITS) (min 1)  index of p-bit being updated.
- phase  output  clog2(CYC_PER_UPDATE) (min 1)  cycle within the current update.
- upd_en  output  N_PBITS  one-hot commit enable; high only when phase==CYC_PER_UPDATE-1.
- sweep_done  output  1  one-cycle pulse coincident with the commit of p-bit N_PBITS-1.
- sample_valid  output  1  one-cycle pulse the cycle after sweep_done, post-burn-in only.
- sweep_count  output  SAMP_W  completed sweeps since start; saturates at all-ones.
- busy  output  1  high in BURN and SAMPLE states.
- done  output  1  one-cycle pulse on entry to IDLE from a run.

Behaviour:
- Reset values: state IDLE; sel, phase, upd_en, sweep_count = 0; sweep_done, sample_valid, busy, done = 0.
- Reset mid-run aborts immediately. It emits no done and no sample_valid.
- States: IDLE, BURN, SAMPLE, FINISH.
- IDLE:
  - start=1 and stop=0 at an edge: latch n_samples and burnin; clear sweep_count, sel, phase.
  - Next state: BURN if burnin>0, else SAMPLE.
  - start and stop both high: remain in IDLE.
- Stepping in BURN and SAMPLE:
  - phase increments every cycle and wraps to 0 after CYC_PER_UPDATE-1.
  - On wrap, sel increments and wraps to 0 after N_PBITS-1.
  - Sweep length is N_PBITS*CYC_PER_UPDATE cycles (15 at defaults).
  - The first upd_en[0] occurs CYC_PER_UPDATE cycles after the edge that accepts start.
- sweep_done: asserted in the commit cycle of sel==N_PBITS-1. sweep_count increments at the same edge.
- BURN -> SAMPLE: at the edge ending sweep number burnin.
- SAMPLE: each sweep end asserts sample_valid on the following cycle, when p-bit states are stable.
  - One sample_valid per sampled sweep.
  - Sampled-sweep counter compared against latched n_samples.
- Stop conditions: sweep end with sampled count == n_samples (n_samples != 0), or stop seen high at any cycle of the current sweep (sticky flag).
  - Stop condition met: go to FINISH. The last sample_valid pulses in FINISH.
  - FINISH lasts 1 cycle, then IDLE with done pulse on the IDLE-entry cycle.
- Stop during BURN: finish current sweep, then FINISH with no sample_valid.
- upd_en, sel and phase are 0 outside BURN/SAMPLE. upd_en is never multi-hot.
- start while busy: ignored. n_samples and burnin changes while busy: ignored (latched values used).
- sweep_count saturates at 2^SAMP_W-1 and does not wrap. Sampling continues.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Defaults, burnin=0, n_samples=2, start pulse at edge T:
  - upd_en sequence 00001,00010,00100,01000,10000 at T+3, T+6, T+9, T+12, T+15.
  - sweep_done at T+15 and T+30; sample_valid at T+16 and T+31.
  - done pulse at T+32; busy low after.
- burnin=3, n_samples=2: no sample_valid for sweeps 1-3. sample_valid at T+61 and T+76. sweep_count=5 at done.
- n_samples=0, stop raised at T+40: current sweep ends T+45 with sample_valid T+46. done at T+47. No further upd_en.
- RST asserted at T+20 mid-run: next cycle all outputs at reset values, no done pulse. A start afterwards restarts from sel=0 with sweep_count=0.
- start and stop both high in IDLE: remains IDLE, busy=0. start during busy: no restart, sample/sweep timing unchanged.
- Parameter sweep N_PBITS=1, CYC_PER_UPDATE=1: upd_en=1 every cycle and sweep_done every cycle. sample_valid count equals n_samples=4.
